// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the FSM state encoding, the port-select values and the default
// access timeout.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        ACK    = 3'd4
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_arbiter_byte_merge.sv
// Purpose: combinational byte-lane merge of an old word with a new word.
// Latency: none (pure combinational).
// Backpressure: none; ports: old_word, new_word, byteen -> merged (lane k from new_word when byteen[k]).
module mem_arbiter_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  byteen,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (byteen[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter between fetch and load/store ports in front of extmem; sub-word stores via read-modify-write.
// Latency: read/full store ack in cycle 2, partial store cycle 3, empty-byteen store cycle 1; every access bounded by TIMEOUT.
// Backpressure: requesters hold req until their one-cycle ack; extmem is paced by mem_done.
// Ports: ph1/reset; i_req/i_adr -> i_ack/i_rdata; d_req/d_we/d_adr/d_byteen/d_wdata -> d_ack/d_rdata; err with ack;
//        mem_adr/mem_data/mem_byteen/mem_rwb/mem_en/mem_done towards extmem.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADR_W   = 11,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             i_req,
    input  logic [31:0]      i_adr,
    output logic             i_ack,
    output logic [31:0]      i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [31:0]      d_adr,
    input  logic [3:0]       d_byteen,
    input  logic [31:0]      d_wdata,
    output logic             d_ack,
    output logic [31:0]      d_rdata,
    output logic             err,
    output logic [ADR_W-1:0] mem_adr,
    inout  wire  [31:0]      mem_data,
    output logic [3:0]       mem_byteen,
    output logic             mem_rwb,
    output logic             mem_en,
    input  logic             mem_done
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    port_t            gnt, gnt_nxt, last_grant;
    logic             take, cap, mrg, tmo, busy;
    logic [ADR_W-1:0] adr_nxt, adr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q, merged, i_rdata_q, d_rdata_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt;

    // Only the word-index bits of the byte addresses matter; the rest wrap.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{i_adr[31:ADR_W+2], i_adr[1:0], d_adr[31:ADR_W+2], d_adr[1:0]};

    mem_arbiter_byte_merge u_merge (
        .old_word (mem_data),
        .new_word (wdata_q),
        .byteen   (be_q),
        .merged   (merged)
    );

    // Bus outputs decode straight from the state register so an
    // asynchronous reset releases the bus and raises rwb immediately.
    assign busy       = (state == RD) || (state == RMW_RD) || (state == WR);
    assign mem_en     = busy;
    assign mem_rwb    = (state != WR);
    assign mem_byteen = (state == WR) ? be_q : 4'hF;
    assign mem_adr    = adr_q;
    assign mem_data   = (state == WR) ? wdata_q : 32'bz;

    assign i_ack   = (state == ACK) && (gnt == PORT_I);
    assign d_ack   = (state == ACK) && (gnt == PORT_D);
    assign err     = (state == ACK) && err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        take      = 1'b0;
        cap       = 1'b0;
        mrg       = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    take = 1'b1;
                    if (i_req && d_req) begin
                        gnt_nxt = (last_grant == PORT_I) ? PORT_D : PORT_I;
                    end else begin
                        gnt_nxt = d_req ? PORT_D : PORT_I;
                    end
                    if ((gnt_nxt == PORT_I) || !d_we) begin
                        state_nxt = RD;
                    end else if (d_byteen == 4'hF) begin
                        state_nxt = WR;
                    end else if (d_byteen == 4'h0) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = RMW_RD;
                    end
                end
            end
            RD: begin
                if (mem_done) begin
                    cap       = 1'b1;
                    state_nxt = ACK;
                end else if (cnt == CNT_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = ACK;
                end
            end
            RMW_RD: begin
                if (mem_done) begin
                    mrg       = 1'b1;
                    state_nxt = WR;
                end else if (cnt == CNT_LAST) begin
                    // Abort before the write half so a stale merge never lands.
                    tmo       = 1'b1;
                    state_nxt = ACK;
                end
            end
            WR: begin
                if (mem_done) begin
                    state_nxt = ACK;
                end else if (cnt == CNT_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign adr_nxt = (gnt_nxt == PORT_I) ? i_adr[ADR_W+1:2] : d_adr[ADR_W+1:2];

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            gnt        <= PORT_I;
            last_grant <= PORT_I;
            adr_q      <= '0;
            be_q       <= 4'h0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            if (take) begin
                gnt        <= gnt_nxt;
                last_grant <= gnt_nxt;
                adr_q      <= adr_nxt;
                be_q       <= d_byteen;
                wdata_q    <= d_wdata;
                err_q      <= 1'b0;
            end
            if (mrg) begin
                wdata_q <= merged;
            end
            if (cap || tmo) begin
                if (gnt == PORT_I) begin
                    i_rdata_q <= tmo ? 32'h0 : mem_data;
                end else begin
                    d_rdata_q <= tmo ? 32'h0 : mem_data;
                end
            end
            if (tmo) begin
                err_q <= 1'b1;
            end
            // Counter restarts on every state change and counts cycles
            // spent waiting for done inside an access state.
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected acks,
// a negedge monitor pops and compares whenever an ack appears.
// Includes a small extmem model that writes on every posedge while rwb=0.
module tb_mem_arbiter;

    localparam int ADR_W   = 11;
    localparam int TIMEOUT = 16;

    logic             ph1 = 1'b0;
    logic             reset = 1'b1;
    logic             i_req = 1'b0;
    logic [31:0]      i_adr = '0;
    logic             i_ack;
    logic [31:0]      i_rdata;
    logic             d_req = 1'b0;
    logic             d_we = 1'b0;
    logic [31:0]      d_adr = '0;
    logic [3:0]       d_byteen = '0;
    logic [31:0]      d_wdata = '0;
    logic             d_ack;
    logic [31:0]      d_rdata;
    logic             err;
    logic [ADR_W-1:0] mem_adr;
    wire  [31:0]      mem_data;
    logic [3:0]       mem_byteen;
    logic             mem_rwb;
    logic             mem_en;
    logic             mem_done = 1'b1;

    mem_arbiter #(.ADR_W(ADR_W), .TIMEOUT(TIMEOUT)) dut (
        .ph1        (ph1),
        .reset      (reset),
        .i_req      (i_req),
        .i_adr      (i_adr),
        .i_ack      (i_ack),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_adr      (d_adr),
        .d_byteen   (d_byteen),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .err        (err),
        .mem_adr    (mem_adr),
        .mem_data   (mem_data),
        .mem_byteen (mem_byteen),
        .mem_rwb    (mem_rwb),
        .mem_en     (mem_en),
        .mem_done   (mem_done)
    );

    always #5 ph1 = ~ph1;

    // extmem model
    logic [31:0] ram [0:(1<<ADR_W)-1];
    bit          ram_init = 1'b0;
    assign mem_data = (mem_en && mem_rwb) ? ram[mem_adr] : 32'bz;
    always @(posedge ph1) begin
        if (!ram_init) begin
            for (int i = 0; i < (1 << ADR_W); i++) ram[i] <= 32'h0;
            ram[4]   <= 32'h8C020004;
            ram_init <= 1'b1;
        end else if (mem_en && !mem_rwb) begin
            ram[mem_adr] <= mem_data;
        end
    end

    int cyc = 0;
    int wr_total = 0;
    always @(posedge ph1) cyc <= cyc + 1;
    always @(negedge ph1) if (mem_en && !mem_rwb) wr_total = wr_total + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          chk_data;
        bit          err;
        int          issue;
        int          lat;
    } exp_t;
    exp_t sb[$];

    // Monitor: compares every ack against the oldest expectation.
    bit prev_ack = 1'b0;
    always @(negedge ph1) begin
        if (!reset) begin
            if (i_ack || d_ack) begin
                chk("ack_single_cycle", {31'b0, prev_ack}, 32'd0);
                if (sb.size() == 0) begin
                    chk("ack_unexpected", {30'b0, d_ack, i_ack}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_port", {30'b0, d_ack, i_ack}, e.is_d ? 32'd2 : 32'd1);
                    chk("ack_err", {31'b0, err}, {31'b0, e.err});
                    if (e.chk_data) chk("ack_rdata", e.is_d ? d_rdata : i_rdata, e.data);
                    if (e.lat >= 0) chk("ack_latency", cyc - e.issue, e.lat);
                end
            end
            prev_ack = i_ack || d_ack;
        end else begin
            prev_ack = 1'b0;
        end
    end

    task automatic wait_ack();
        int n = 0;
        while (!(i_ack || d_ack) && n < 100) begin
            @(posedge ph1); #1;
            n++;
        end
        chk("ack_wait", {31'b0, (i_ack || d_ack)}, 32'd1);
    endtask

    // One transaction; called 1 time unit after a posedge with the DUT idle.
    task automatic xact(input bit is_d, input bit we, input logic [31:0] adr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] exp_data, input bit chk_data, input bit exp_err,
                        input int lat, input logic [ADR_W-1:0] c1_adr, input bit c1_en,
                        input bit c1_rwb, input logic [3:0] c1_be);
        exp_t e;
        e = '{is_d, exp_data, chk_data, exp_err, cyc, lat};
        sb.push_back(e);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_adr = adr; d_byteen = be; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_adr = adr;
        end
        @(posedge ph1); #1;
        chk("c1_en", {31'b0, mem_en}, {31'b0, c1_en});
        chk("c1_rwb", {31'b0, mem_rwb}, {31'b0, c1_rwb});
        chk("c1_byteen", {28'b0, mem_byteen}, {28'b0, c1_be});
        if (c1_en) chk("c1_adr", {21'b0, mem_adr}, {21'b0, c1_adr});
        wait_ack();
        @(posedge ph1); #1;
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        int wr0;
        int acks;
        repeat (3) @(posedge ph1);
        #1;
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_rwb", {31'b0, mem_rwb}, 32'd1);
        chk("rst_i_ack", {31'b0, i_ack}, 32'd0);
        chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        reset = 1'b0;
        @(posedge ph1); #1;

        // fetch
        xact(0, 0, 32'h10, 4'h0, 32'h0, 32'h8C020004, 1, 0, 2, 11'd4, 1, 1, 4'hF);

        // full store then read back
        wr0 = wr_total;
        xact(1, 1, 32'h20, 4'hF, 32'hCAFEBABE, 32'h0, 0, 0, 2, 11'd8, 1, 0, 4'hF);
        chk("full_wr_cycles", wr_total - wr0, 32'd1);
        chk("full_ram", ram[8], 32'hCAFEBABE);
        xact(1, 0, 32'h20, 4'hF, 32'h0, 32'hCAFEBABE, 1, 0, 2, 11'd8, 1, 1, 4'hF);

        // partial store over a known word
        xact(1, 1, 32'h20, 4'hF, 32'h11223344, 32'h0, 0, 0, 2, 11'd8, 1, 0, 4'hF);
        wr0 = wr_total;
        xact(1, 1, 32'h20, 4'b0010, 32'h0000AB00, 32'h0, 0, 0, 3, 11'd8, 1, 1, 4'hF);
        chk("part_wr_cycles", wr_total - wr0, 32'd1);
        chk("part_ram", ram[8], 32'h1122AB44);

        // empty byteen: ack without touching memory
        wr0 = wr_total;
        xact(1, 1, 32'h24, 4'h0, 32'hDEADBEEF, 32'h0, 0, 0, 1, 11'd9, 0, 1, 4'hF);
        chk("empty_wr_cycles", wr_total - wr0, 32'd0);

        // upper and low address bits ignored
        xact(1, 0, 32'h00002013, 4'hF, 32'h0, 32'h8C020004, 1, 0, 2, 11'd4, 1, 1, 4'hF);

        // timeouts
        mem_done = 1'b0;
        xact(1, 0, 32'h20, 4'hF, 32'h0, 32'h0, 1, 1, TIMEOUT + 1, 11'd8, 1, 1, 4'hF);
        wr0 = wr_total;
        xact(1, 1, 32'h20, 4'b0010, 32'h0000FF00, 32'h0, 1, 1, TIMEOUT + 1, 11'd8, 1, 1, 4'hF);
        chk("tmo_wr_cycles", wr_total - wr0, 32'd0);
        chk("tmo_ram", ram[8], 32'h1122AB44);

        // reset in the middle of a store
        d_req = 1'b1; d_we = 1'b1; d_adr = 32'h30; d_byteen = 4'hF; d_wdata = 32'h55AA55AA;
        @(posedge ph1); #1;
        chk("mid_wr_rwb", {31'b0, mem_rwb}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_rwb", {31'b0, mem_rwb}, 32'd1);
        chk("mid_rst_en", {31'b0, mem_en}, 32'd0);
        chk("mid_rst_ack", {31'b0, d_ack}, 32'd0);
        d_req = 1'b0;
        mem_done = 1'b1;
        @(posedge ph1); #1;
        reset = 1'b0;

        // contention from reset: D, I, D, I
        sb.push_back('{1, 32'h1122AB44, 1, 0, cyc, 2});
        sb.push_back('{0, 32'h8C020004, 1, 0, cyc, 5});
        sb.push_back('{1, 32'h1122AB44, 1, 0, cyc, 8});
        sb.push_back('{0, 32'h8C020004, 1, 0, cyc, 11});
        i_req = 1'b1; i_adr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_adr = 32'h20; d_byteen = 4'hF;
        acks = 0;
        for (int n = 0; n < 200 && acks < 4; n++) begin
            @(posedge ph1); #1;
            if (i_ack || d_ack) acks++;
        end
        chk("contention_acks", acks, 32'd4);
        @(posedge ph1); #1;
        i_req = 1'b0;
        d_req = 1'b0;

        repeat (5) @(posedge ph1);
        #1;
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
